// File: rtl/mem_pkg.sv
// Shared types and constants for the MMIPS memory responder and its storage array.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_W      = 32;
    localparam int BE_W        = 4;
    localparam int MAX_LATENCY = 15;
    localparam int CNT_W       = 4;

endpackage

// File: rtl/mem_array.sv
// Word storage with byte-enable synchronous write and registered read.
// Read data is zero whenever no read is enabled; storage is never reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Same-edge read returns the pre-write contents of the word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= (en && !we) ? mem[addr] : '0;
        end
    end

endmodule

// File: rtl/mips_mem_responder.sv
// Memory responder for the MMIPS CPU bus: req/ack handshake with LATENCY wait states.
// Optional MEM_ALIGN_CHECK_EN flags misaligned word accesses with err and suppresses them.
//
// Handshake: req is sampled only in IDLE and must stay high until captured; the
// captured request completes with a one-cycle ack pulse, with rdata/err valid
// alongside it. Dropping req after capture does not cancel the transaction.
module mips_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic              ack,
    output logic [WORD_W-1:0] rdata,
    output logic              err
);

    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LATENCY);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               lat_we;
    logic [31:0]        lat_addr;
    logic [WORD_W-1:0]  lat_wdata;
    logic [BE_W-1:0]    lat_be;
    logic               misaligned;
    logic               mem_en;
    logic               err_q;
    logic               unused_bits;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (lat_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Bits above the word index are ignored so addresses wrap around the array.
    assign unused_bits = ^{lat_addr[31:ADDR_W+2], lat_addr[1:0]};

    // The array sees exactly one enabled cycle per transaction: the RESP cycle.
    assign mem_en = (state == RESP) && !misaligned;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            ack       <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ack   <= 1'b0;
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_we    <= we;
                        lat_addr  <= addr;
                        lat_wdata <= wdata;
                        lat_be    <= be;
                        cnt       <= LAT_INIT;
                        state     <= (LATENCY == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == 1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    ack   <= 1'b1;
                    err_q <= misaligned;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign err = err_q;

    mem_array #(
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .en    (mem_en),
        .we    (lat_we),
        .addr  (lat_addr[ADDR_W+1:2]),
        .wdata (lat_wdata),
        .be    (lat_be),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder: LATENCY=2 and LATENCY=0 instances side by side.
module tb_mips_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req2 = 1'b0;
    logic        req0 = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic        ack2, ack0, err2, err0;
    logic [31:0] rdata2, rdata0;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic sel = 1'b0;

    logic        cur_ack;
    logic [31:0] cur_rdata;
    logic        cur_err;
    assign cur_ack   = sel ? ack0 : ack2;
    assign cur_rdata = sel ? rdata0 : rdata2;
    assign cur_err   = sel ? err0 : err2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mips_mem_responder #(.ADDR_W(10), .LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .req(req2), .we(we), .addr(addr), .wdata(wdata),
        .be(be), .ack(ack2), .rdata(rdata2), .err(err2)
    );

    mips_mem_responder #(.ADDR_W(10), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we), .addr(addr), .wdata(wdata),
        .be(be), .ack(ack0), .rdata(rdata0), .err(err0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction; req is dropped right after capture. lat counts edges from capture to ack.
    task automatic xact(input logic s, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        output logic [31:0] rd, output logic er, output int lat);
        sel = s;
        @(negedge clk);
        we = w; addr = a; wdata = d; be = b;
        if (s) req0 = 1'b1; else req2 = 1'b1;
        @(posedge clk);
        #1;
        req0 = 1'b0; req2 = 1'b0;
        lat = 0; rd = 'x; er = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (cur_ack) begin
                lat = i; rd = cur_rdata; er = cur_err;
                break;
            end
        end
        @(negedge clk);
        chk("ack_single_pulse", {31'b0, cur_ack}, 32'd0);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          t_ack[3];
    logic        got;
    logic        seen;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_ack", {31'b0, ack2}, 32'd0);
        chk("reset_rdata", rdata2, 32'd0);
        chk("reset_err", {31'b0, err2}, 32'd0);
        chk("reset_ack_l0", {31'b0, ack0}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Preload word 5, then read it back
        xact(1'b0, 1'b1, 32'h14, 32'h8C220004, 4'hF, rd, er, lat);
        chk("wr5_latency", lat, 32'd3);
        chk("wr5_rdata_zero", rd, 32'd0);
        chk("wr5_err", {31'b0, er}, 32'd0);
        xact(1'b0, 1'b0, 32'h14, 32'h0, 4'h0, rd, er, lat);
        chk("rd5_latency", lat, 32'd3);
        chk("rd5_data", rd, 32'h8C220004);
        chk("rd5_err", {31'b0, er}, 32'd0);

        // Byte-enable write and be=0000
        xact(1'b0, 1'b1, 32'h0C, 32'h11223344, 4'hF, rd, er, lat);
        xact(1'b0, 1'b1, 32'h0C, 32'hAABBCCDD, 4'b0101, rd, er, lat);
        chk("bytewr_latency", lat, 32'd3);
        xact(1'b0, 1'b0, 32'h0C, 32'h0, 4'h0, rd, er, lat);
        chk("bytewr_data", rd, 32'h11BB33DD);
        xact(1'b0, 1'b1, 32'h0C, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
        chk("be0_acked", lat, 32'd3);
        xact(1'b0, 1'b0, 32'h0C, 32'h0, 4'h0, rd, er, lat);
        chk("be0_unchanged", rd, 32'h11BB33DD);

        // Back-to-back reads with req held continuously
        xact(1'b0, 1'b1, 32'h00, 32'hA0000000, 4'hF, rd, er, lat);
        xact(1'b0, 1'b1, 32'h04, 32'hA1111111, 4'hF, rd, er, lat);
        xact(1'b0, 1'b1, 32'h08, 32'hA2222222, 4'hF, rd, er, lat);
        sel = 1'b0;
        @(negedge clk);
        we = 1'b0; be = 4'hF; addr = 32'h0; req2 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (ack2) begin
                    got = 1'b1;
                    break;
                end
            end
            chk("b2b_ack_seen", {31'b0, got}, 32'd1);
            t_ack[k] = cyc;
            case (k)
                0: chk("b2b_data0", rdata2, 32'hA0000000);
                1: chk("b2b_data1", rdata2, 32'hA1111111);
                default: chk("b2b_data2", rdata2, 32'hA2222222);
            endcase
            if (k < 2) addr = 32'(k + 1) * 4;
            else req2 = 1'b0;
        end
        chk("b2b_spacing01", t_ack[1] - t_ack[0], 32'd4);
        chk("b2b_spacing12", t_ack[2] - t_ack[1], 32'd4);
        repeat (6) @(negedge clk);
        chk("b2b_no_extra_ack", {31'b0, ack2}, 32'd0);

        // Reset during WAIT discards a pending write
        xact(1'b0, 1'b1, 32'h20, 32'hDEADBEEF, 4'hF, rd, er, lat);
        @(negedge clk);
        we = 1'b1; addr = 32'h20; wdata = 32'h12345678; be = 4'hF; req2 = 1'b1;
        @(posedge clk);
        #1;
        req2 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        @(negedge clk);
        if (ack2) seen = 1'b1;
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ack2) seen = 1'b1;
        end
        chk("rst_mid_no_ack", {31'b0, seen}, 32'd0);
        xact(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        chk("rst_mid_word_kept", rd, 32'hDEADBEEF);

        // Misaligned write and read
        xact(1'b0, 1'b1, 32'h21, 32'h55667788, 4'hF, rd, er, lat);
        chk("mis_wr_latency", lat, 32'd3);
`ifdef MEM_ALIGN_CHECK_EN
        chk("mis_wr_err", {31'b0, er}, 32'd1);
        xact(1'b0, 1'b0, 32'h22, 32'h0, 4'h0, rd, er, lat);
        chk("mis_rd_err", {31'b0, er}, 32'd1);
        chk("mis_rd_data_zero", rd, 32'd0);
        xact(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        chk("mis_word8_unchanged", rd, 32'hDEADBEEF);
`else
        chk("mis_wr_err", {31'b0, er}, 32'd0);
        xact(1'b0, 1'b0, 32'h22, 32'h0, 4'h0, rd, er, lat);
        chk("mis_rd_err", {31'b0, er}, 32'd0);
        chk("mis_word8_written", rd, 32'h55667788);
`endif

        // LATENCY = 0 instance, address wrap
        xact(1'b1, 1'b1, 32'h0, 32'hC0FFEE00, 4'hF, rd, er, lat);
        chk("l0_wr_latency", lat, 32'd1);
        xact(1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat);
        chk("l0_rd_latency", lat, 32'd1);
        chk("l0_wrap_data", rd, 32'hC0FFEE00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
